key_event_ctrl: RTL



---
 rtl/key_event_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns debounced key levels into press/release/long/repeat events and
// serializes them through a round-robin arbiter. Define KEY_REPEAT_EN to enable auto-repeat.
module key_event_ctrl #(
  parameter int NUM_KEYS   = 4,
  parameter int KEY_W      = 2,
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic [1:0]          evt_type,
  output logic                overflow
);

  localparam logic [1:0]  T_PRESS   = 2'b00;
  localparam logic [1:0]  T_RELEASE = 2'b01;
  localparam logic [1:0]  T_LONG    = 2'b10;
  localparam logic [1:0]  T_REPEAT  = 2'b11;
  localparam logic [31:0] LONG_LAST = 32'(LONG_CNT - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CNT - 1);
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic [NUM_KEYS-1:0]       key_prev, phase, phase_nxt;
  logic [NUM_KEYS-1:0]       pend_v, pend_v_nxt, new_v, drop, granted;
  logic [NUM_KEYS-1:0][1:0]  pend_t, pend_t_nxt, new_t;
  logic [NUM_KEYS-1:0][31:0] cnt, cnt_nxt;
  logic [KEY_W-1:0]          ptr, grant_idx;
  logic [1:0]                grant_type;
  logic                      grant_found, loadable;
  int                        best;

  // Round-robin: the pending slot closest after ptr (distance 0 = ptr+1) wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_type  = T_PRESS;
    best        = NUM_KEYS;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pend_v[i] && ((i + NUM_KEYS - 1 - int'(ptr)) % NUM_KEYS) < best) begin
        best        = (i + NUM_KEYS - 1 - int'(ptr)) % NUM_KEYS;
        grant_found = 1'b1;
        grant_idx   = KEY_W'(i);
        grant_type  = pend_t[i];
      end
    end
    loadable = !evt_valid || evt_ready;
    granted  = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      granted[i] = grant_found && loadable && (grant_idx == KEY_W'(i));
  end

  always_comb begin
    new_v      = '0;
    new_t      = '0;
    cnt_nxt    = cnt;
    phase_nxt  = phase;
    pend_v_nxt = pend_v & ~granted;
    pend_t_nxt = pend_t;
    drop       = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_state[i] && !key_prev[i]) begin
        new_v[i] = 1'b1; new_t[i] = T_PRESS;
        cnt_nxt[i] = '0; phase_nxt[i] = 1'b0;
      end else if (!key_state[i] && key_prev[i]) begin
        new_v[i] = 1'b1; new_t[i] = T_RELEASE;
        cnt_nxt[i] = '0; phase_nxt[i] = 1'b0;
      end else if (key_state[i]) begin
        if (!phase[i] && cnt[i] == LONG_LAST) begin
          new_v[i] = 1'b1; new_t[i] = T_LONG;
          cnt_nxt[i] = '0; phase_nxt[i] = 1'b1;
        end else if (phase[i] && REP_EN && cnt[i] == REP_LAST) begin
          new_v[i] = 1'b1; new_t[i] = T_REPEAT;
          cnt_nxt[i] = '0;
        end else if ((!phase[i] || REP_EN) && cnt[i] != '1) begin
          cnt_nxt[i] = cnt[i] + 32'd1;
        end
      end

      // A release cancels a queued long/repeat, and annihilates an unsent press.
      if (new_v[i]) begin
        if (!pend_v_nxt[i]) begin
          pend_v_nxt[i] = 1'b1;
          pend_t_nxt[i] = new_t[i];
        end else begin
          drop[i] = 1'b1;
          if (new_t[i] == T_RELEASE && pend_t[i][1])
            pend_t_nxt[i] = T_RELEASE;
          else if (new_t[i] == T_RELEASE && pend_t[i] == T_PRESS)
            pend_v_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev  <= '0;
      cnt       <= '0;
      phase     <= '0;
      pend_v    <= '0;
      pend_t    <= '0;
      ptr       <= KEY_W'(NUM_KEYS - 1);
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= T_PRESS;
      overflow  <= 1'b0;
    end else begin
      key_prev <= key_state;
      cnt      <= cnt_nxt;
      phase    <= phase_nxt;
      pend_v   <= pend_v_nxt;
      pend_t   <= pend_t_nxt;
      overflow <= |drop;
      if (loadable) begin
        if (grant_found) begin
          evt_valid <= 1'b1;
          evt_key   <= grant_idx;
          evt_type  <= grant_type;
          ptr       <= grant_idx;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule
